data_mem_access_unit: RTL and testbench

//  Memory-side responder for the datapath load/store interface. Accepts one request per

---
 rtl/data_mem_access_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// Load/store responder for the datapath: drives a word-addressed synchronous RAM with byte
// enables, splitting misaligned accesses into two word accesses, and returns extended load data.
module data_mem_access_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        RESP
    } state_t;

    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b100;
    localparam logic [2:0] TYPE_HU = 3'b101;

    localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        split_q, split_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_err;
    logic        req_split;
    logic [7:0]  lane_en;
    logic [63:0] lane_data;
    logic [63:0] store_data;

    function automatic logic [3:0] base_mask(input logic [2:0] t);
        logic [3:0] m;
        case (t[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // The two fetched words form a little-endian window that the byte offset slides across.
    function automatic logic [31:0] extract(input logic [63:0] words,
                                            input logic [1:0]  off,
                                            input logic [2:0]  typ);
        logic [31:0] sh;
        logic [31:0] r;
        sh = 32'(words >> {off, 3'b000});
        case (typ)
            TYPE_B:  r = {{24{sh[7]}}, sh[7:0]};
            TYPE_H:  r = {{16{sh[15]}}, sh[15:0]};
            TYPE_BU: r = {24'h000000, sh[7:0]};
            TYPE_HU: r = {16'h0000, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    always_comb begin
        req_err   = 1'b1;
        req_split = 1'b0;
        case (req_type)
            TYPE_B, TYPE_H, TYPE_W: req_err = 1'b0;
            TYPE_BU, TYPE_HU:       req_err = req_we;
            default:                req_err = 1'b1;
        endcase
        case (req_type)
            TYPE_H, TYPE_HU: req_split = (req_addr[1:0] == 2'b11);
            TYPE_W:          req_split = (req_addr[1:0] != 2'b00);
            default:         req_split = 1'b0;
        endcase
    end

    // Store lanes span two words; lanes 3:0 feed the first access and 7:4 the second.
    always_comb begin
        lane_en    = {4'b0000, base_mask(type_q)} << addr_q[1:0];
        lane_data  = {32'h00000000, wdata_q} << {addr_q[1:0], 3'b000};
        store_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (lane_en[i]) begin
                store_data[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            cnt_q   <= '0;
            word0_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            split_q <= split_d;
            cnt_q   <= cnt_d;
            word0_q <= word0_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        type_d    = type_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        split_d   = split_q;
        cnt_d     = cnt_q;
        word0_d   = word0_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    type_d  = req_type;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    split_d = req_split && !req_err;
                    if (req_err) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE0;
                    end
                end
            end
            ISSUE0: begin
                mem_en   = 1'b1;
                mem_addr = addr_q[31:2];
                cnt_d    = '0;
                if (we_q) begin
                    mem_we    = lane_en[3:0];
                    mem_wdata = store_data[31:0];
                    if (split_q) begin
                        state_d = ISSUE1;
                    end else begin
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end else begin
                    state_d = WAIT0;
                end
            end
            WAIT0: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) begin
                    if (split_q) begin
                        word0_d = mem_rdata;
                        state_d = ISSUE1;
                    end else begin
                        rdata_d = extract({32'h00000000, mem_rdata}, addr_q[1:0], type_q);
                        state_d = RESP;
                    end
                end
            end
            ISSUE1: begin
                mem_en   = 1'b1;
                mem_addr = addr_q[31:2] + 30'd1;
                cnt_d    = '0;
                if (we_q) begin
                    mem_we    = lane_en[7:4];
                    mem_wdata = store_data[63:32];
                    rdata_d   = '0;
                    state_d   = RESP;
                end else begin
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) begin
                    rdata_d = extract({mem_rdata, word0_q}, addr_q[1:0], type_q);
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: a byte-level reference memory predicts
// load results, RAM write lanes and response timing for directed and random requests.
module tb_data_mem_access_unit;

    localparam int L = 3;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        int          cyc;
        logic [29:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } memop_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    memop_t      memq[$];
    rsp_t        rspq[$];
    memop_t      mon_op;
    rsp_t        mon_rsp;
    logic [31:0] ram [logic [29:0]];
    logic [7:0]  refmem [logic [31:0]];
    logic [31:0] pipe [L];

    data_mem_access_unit #(.MEM_LAT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_rd(input logic [29:0] a);
        return ram.exists(a) ? ram[a] : 32'h00000000;
    endfunction

    function automatic logic [7:0] refbyte(input logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : 8'h00;
    endfunction

    // RAM with MEM_LAT read pipeline; non-read slots carry junk so early/late capture shows up.
    always @(posedge clk) begin
        if (mem_en && mem_we != 4'b0000) begin
            logic [31:0] w;
            w = ram_rd(mem_addr);
            for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            end
            ram[mem_addr] = w;
        end
        pipe[0] <= (mem_en && mem_we == 4'b0000) ? ram_rd(mem_addr) : $urandom;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1];

    always @(negedge clk) begin
        if (mem_en) begin
            mon_op.cyc   = cyc;
            mon_op.addr  = mem_addr;
            mon_op.we    = mem_we;
            mon_op.wdata = mem_wdata;
            memq.push_back(mon_op);
        end
        if (rsp_valid) begin
            mon_rsp.cyc   = cyc;
            mon_rsp.rdata = rsp_rdata;
            mon_rsp.err   = rsp_err;
            rspq.push_back(mon_rsp);
        end
    end

    task automatic preload(input logic [29:0] wa, input logic [31:0] v);
        ram[wa] = v;
        for (int k = 0; k < 4; k++) refmem[{wa, 2'b00} + 32'(k)] = v[8*k +: 8];
    endtask

    function automatic int nbytes(input logic [2:0] t);
        return (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit legal(input logic we, input logic [2:0] t);
        if (we) return (t == 3'd0 || t == 3'd1 || t == 3'd2);
        return (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5);
    endfunction

    // Reference: byte-by-byte view of the request; op cycles are offsets from the accept cycle.
    task automatic model_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er,
                             output int lat, output int nops, output memop_t ops [2]);
        int          n;
        int          pos;
        bit          split;
        logic [3:0]  we0, we1;
        logic [31:0] d0, d1;
        n     = nbytes(t);
        split = (int'(a[1:0]) + n) > 4;
        er    = !legal(we, t);
        rd    = '0;
        we0   = '0;
        we1   = '0;
        d0    = '0;
        d1    = '0;
        for (int k = 0; k < n; k++) begin
            pos = int'(a[1:0]) + k;
            if (pos < 4) begin
                we0[pos] = 1'b1;
                d0[8*pos +: 8] = wd[8*k +: 8];
            end else begin
                we1[pos-4] = 1'b1;
                d1[8*(pos-4) +: 8] = wd[8*k +: 8];
            end
        end
        ops[0].cyc   = 1;
        ops[0].addr  = a[31:2];
        ops[0].we    = we ? we0 : 4'b0000;
        ops[0].wdata = we ? d0 : 32'h0;
        ops[1].cyc   = we ? 2 : 2 + L;
        ops[1].addr  = a[31:2] + 30'd1;
        ops[1].we    = we ? we1 : 4'b0000;
        ops[1].wdata = we ? d1 : 32'h0;
        if (er) begin
            lat  = 1;
            nops = 0;
        end else if (we) begin
            lat  = split ? 3 : 2;
            nops = split ? 2 : 1;
            for (int k = 0; k < n; k++) refmem[a + 32'(k)] = wd[8*k +: 8];
        end else begin
            lat  = split ? 3 + 2 * L : 2 + L;
            nops = split ? 2 : 1;
            for (int k = 0; k < n; k++) rd = rd | (32'(refbyte(a + 32'(k))) << (8 * k));
            if (!t[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFFFFFF << (8 * n));
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                             input logic [31:0] wd, output int ta, output int tr,
                             output logic [31:0] rd, output logic er);
        memq.delete();
        rspq.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        ta = -1;
        for (int i = 0; i < 50 && ta < 0; i++) begin
            @(negedge clk);
            if (req_ready) ta = cyc;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_type  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int i = 0; i < 40 && rspq.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (rspq.size() > 0 && ta >= 0) begin
            tr = rspq[0].cyc;
            rd = rspq[0].rdata;
            er = rspq[0].err;
        end else begin
            tr = -1000;
            rd = 32'hxxxxxxxx;
            er = 1'bx;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (req_ready !== 1'b0) begin nerr++; $display("[TB] FAIL rst_ready: got %b expected 0", req_ready); end
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("[TB] FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("[TB] FAIL rst_rsp_err: got %b expected 0", rsp_err); end
        nvec++; if (mem_en !== 1'b0) begin nerr++; $display("[TB] FAIL rst_mem_en: got %b expected 0", mem_en); end
        nvec++; if (mem_we !== 4'b0000) begin nerr++; $display("[TB] FAIL rst_mem_we: got %b expected 0000", mem_we); end
        nvec++; if (mem_addr !== 30'h0) begin nerr++; $display("[TB] FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        nvec++; if (mem_wdata !== 32'h0) begin nerr++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        nvec++; if (rsp_rdata !== 32'h0) begin nerr++; $display("[TB] FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        nvec++; if (req_ready !== 1'b1) begin nerr++; $display("[TB] FAIL rst_ready_after: got %b expected 1", req_ready); end
    endtask

    task automatic test_load_byte();
        int ta, tr;
        logic [31:0] rd;
        logic er;
        preload(30'h40, 32'h80FF1234);
        drive_req(1'b0, 3'b000, 32'h103, $urandom, ta, tr, rd, er);
        nvec++; if (tr - ta !== 2 + L) begin nerr++; $display("[TB] FAIL lb_latency: got %0d expected %0d", tr - ta, 2 + L); end
        nvec++; if (rd !== 32'hFFFFFF80) begin nerr++; $display("[TB] FAIL lb_rdata: got %h expected ffffff80", rd); end
        nvec++; if (er !== 1'b0) begin nerr++; $display("[TB] FAIL lb_err: got %b expected 0", er); end
        nvec++;
        if (memq.size() !== 1) begin
            nerr++; $display("[TB] FAIL lb_mem_count: got %0d expected 1", memq.size());
        end else begin
            nvec++; if (memq[0].addr !== 30'h40) begin nerr++; $display("[TB] FAIL lb_mem_addr: got %h expected 40", memq[0].addr); end
            nvec++; if (memq[0].cyc - ta !== 1) begin nerr++; $display("[TB] FAIL lb_mem_cycle: got %0d expected 1", memq[0].cyc - ta); end
        end
        repeat (2) @(negedge clk);
        nvec++; if (rsp_rdata !== 32'hFFFFFF80) begin nerr++; $display("[TB] FAIL lb_rdata_hold: got %h expected ffffff80", rsp_rdata); end
        drive_req(1'b0, 3'b100, 32'h103, $urandom, ta, tr, rd, er);
        nvec++; if (tr - ta !== 2 + L) begin nerr++; $display("[TB] FAIL lbu_latency: got %0d expected %0d", tr - ta, 2 + L); end
        nvec++; if (rd !== 32'h00000080) begin nerr++; $display("[TB] FAIL lbu_rdata: got %h expected 00000080", rd); end
        nvec++; if (memq.size() !== 1) begin nerr++; $display("[TB] FAIL lbu_mem_count: got %0d expected 1", memq.size()); end
    endtask

    task automatic test_store_half();
        int ta, tr;
        logic [31:0] rd;
        logic er;
        preload(30'h80, 32'h11111111);
        drive_req(1'b1, 3'b001, 32'h202, 32'h1234ABCD, ta, tr, rd, er);
        nvec++; if (tr - ta !== 2) begin nerr++; $display("[TB] FAIL sh_latency: got %0d expected 2", tr - ta); end
        nvec++; if (rd !== 32'h0) begin nerr++; $display("[TB] FAIL sh_rdata: got %h expected 0", rd); end
        nvec++;
        if (memq.size() !== 1) begin
            nerr++; $display("[TB] FAIL sh_mem_count: got %0d expected 1", memq.size());
        end else begin
            nvec++; if (memq[0].addr !== 30'h80) begin nerr++; $display("[TB] FAIL sh_mem_addr: got %h expected 80", memq[0].addr); end
            nvec++; if (memq[0].we !== 4'b1100) begin nerr++; $display("[TB] FAIL sh_mem_we: got %b expected 1100", memq[0].we); end
            nvec++; if (memq[0].wdata !== 32'hABCD0000) begin nerr++; $display("[TB] FAIL sh_mem_wdata: got %h expected abcd0000", memq[0].wdata); end
            nvec++; if (memq[0].cyc - ta !== 1) begin nerr++; $display("[TB] FAIL sh_mem_cycle: got %0d expected 1", memq[0].cyc - ta); end
        end
        nvec++; if (ram_rd(30'h80) !== 32'hABCD1111) begin nerr++; $display("[TB] FAIL sh_ram_word: got %h expected abcd1111", ram_rd(30'h80)); end
    endtask

    task automatic test_split_load();
        int ta, tr;
        logic [31:0] rd;
        logic er;
        preload(30'h40, 32'h44332211);
        preload(30'h41, 32'h88776655);
        drive_req(1'b0, 3'b010, 32'h101, $urandom, ta, tr, rd, er);
        nvec++; if (tr - ta !== 3 + 2 * L) begin nerr++; $display("[TB] FAIL lw_split_latency: got %0d expected %0d", tr - ta, 3 + 2 * L); end
        nvec++; if (rd !== 32'h55443322) begin nerr++; $display("[TB] FAIL lw_split_rdata: got %h expected 55443322", rd); end
        nvec++;
        if (memq.size() !== 2) begin
            nerr++; $display("[TB] FAIL lw_split_mem_count: got %0d expected 2", memq.size());
        end else begin
            nvec++; if (memq[0].addr !== 30'h40) begin nerr++; $display("[TB] FAIL lw_split_addr0: got %h expected 40", memq[0].addr); end
            nvec++; if (memq[1].addr !== 30'h41) begin nerr++; $display("[TB] FAIL lw_split_addr1: got %h expected 41", memq[1].addr); end
            nvec++; if (memq[1].cyc - ta !== 2 + L) begin nerr++; $display("[TB] FAIL lw_split_cycle1: got %0d expected %0d", memq[1].cyc - ta, 2 + L); end
        end
        drive_req(1'b0, 3'b001, 32'h103, $urandom, ta, tr, rd, er);
        nvec++; if (rd !== 32'h00005544) begin nerr++; $display("[TB] FAIL lh_split_rdata: got %h expected 00005544", rd); end
        nvec++; if (tr - ta !== 3 + 2 * L) begin nerr++; $display("[TB] FAIL lh_split_latency: got %0d expected %0d", tr - ta, 3 + 2 * L); end
    endtask

    task automatic test_split_store_wrap();
        int ta, tr;
        logic [31:0] rd;
        logic er;
        drive_req(1'b1, 3'b010, 32'hFFFFFFFF, 32'hDDCCBBAA, ta, tr, rd, er);
        nvec++; if (tr - ta !== 3) begin nerr++; $display("[TB] FAIL sw_wrap_latency: got %0d expected 3", tr - ta); end
        nvec++;
        if (memq.size() !== 2) begin
            nerr++; $display("[TB] FAIL sw_wrap_mem_count: got %0d expected 2", memq.size());
        end else begin
            nvec++; if (memq[0].addr !== 30'h3FFFFFFF) begin nerr++; $display("[TB] FAIL sw_wrap_addr0: got %h expected 3fffffff", memq[0].addr); end
            nvec++; if (memq[0].we !== 4'b1000) begin nerr++; $display("[TB] FAIL sw_wrap_we0: got %b expected 1000", memq[0].we); end
            nvec++; if (memq[0].wdata !== 32'hAA000000) begin nerr++; $display("[TB] FAIL sw_wrap_wdata0: got %h expected aa000000", memq[0].wdata); end
            nvec++; if (memq[1].addr !== 30'h0) begin nerr++; $display("[TB] FAIL sw_wrap_addr1: got %h expected 0", memq[1].addr); end
            nvec++; if (memq[1].we !== 4'b0111) begin nerr++; $display("[TB] FAIL sw_wrap_we1: got %b expected 0111", memq[1].we); end
            nvec++; if (memq[1].wdata !== 32'h00DDCCBB) begin nerr++; $display("[TB] FAIL sw_wrap_wdata1: got %h expected 00ddccbb", memq[1].wdata); end
            nvec++; if (memq[1].cyc - ta !== 2) begin nerr++; $display("[TB] FAIL sw_wrap_cycle1: got %0d expected 2", memq[1].cyc - ta); end
        end
    endtask

    task automatic test_error();
        int ta, tr;
        logic [31:0] rd;
        logic er;
        drive_req(1'b0, 3'b011, 32'h100, $urandom, ta, tr, rd, er);
        nvec++; if (tr - ta !== 1) begin nerr++; $display("[TB] FAIL err_load_latency: got %0d expected 1", tr - ta); end
        nvec++; if (er !== 1'b1) begin nerr++; $display("[TB] FAIL err_load_flag: got %b expected 1", er); end
        nvec++; if (rd !== 32'h0) begin nerr++; $display("[TB] FAIL err_load_rdata: got %h expected 0", rd); end
        nvec++; if (memq.size() !== 0) begin nerr++; $display("[TB] FAIL err_load_mem_count: got %0d expected 0", memq.size()); end
        drive_req(1'b1, 3'b100, 32'h100, $urandom, ta, tr, rd, er);
        nvec++; if (tr - ta !== 1) begin nerr++; $display("[TB] FAIL err_store_latency: got %0d expected 1", tr - ta); end
        nvec++; if (er !== 1'b1) begin nerr++; $display("[TB] FAIL err_store_flag: got %b expected 1", er); end
        nvec++; if (memq.size() !== 0) begin nerr++; $display("[TB] FAIL err_store_mem_count: got %0d expected 0", memq.size()); end
    endtask

    task automatic test_reset_mid();
        int ta, tr;
        logic [31:0] rd;
        logic er;
        preload(30'h40, 32'h44332211);
        memq.delete();
        rspq.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_type  = 3'b010;
        req_addr  = 32'h101;
        ta = -1;
        for (int i = 0; i < 50 && ta < 0; i++) begin
            @(negedge clk);
            if (req_ready) ta = cyc;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        nvec++; if (req_ready !== 1'b1) begin nerr++; $display("[TB] FAIL rstmid_ready: got %b expected 1", req_ready); end
        repeat (4 * L + 6) @(negedge clk);
        #1;
        nvec++; if (rspq.size() !== 0) begin nerr++; $display("[TB] FAIL rstmid_no_rsp: got %0d expected 0", rspq.size()); end
        nvec++; if (memq.size() !== 1) begin nerr++; $display("[TB] FAIL rstmid_mem_count: got %0d expected 1", memq.size()); end
        drive_req(1'b0, 3'b010, 32'h100, $urandom, ta, tr, rd, er);
        nvec++; if (rd !== 32'h44332211) begin nerr++; $display("[TB] FAIL rstmid_next_rdata: got %h expected 44332211", rd); end
        nvec++; if (tr - ta !== 2 + L) begin nerr++; $display("[TB] FAIL rstmid_next_latency: got %0d expected %0d", tr - ta, 2 + L); end
    endtask

    task automatic test_back_to_back();
        int ta, tb;
        preload(30'h40, 32'h44332211);
        preload(30'h41, 32'h88776655);
        memq.delete();
        rspq.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_type  = 3'b010;
        req_addr  = 32'h100;
        ta = -1;
        for (int i = 0; i < 50 && ta < 0; i++) begin
            @(negedge clk);
            if (req_ready) ta = cyc;
        end
        @(posedge clk);
        #1;
        req_type = 3'b100;
        req_addr = 32'h106;
        tb = -1;
        for (int i = 0; i < 50 && tb < 0; i++) begin
            @(negedge clk);
            if (req_ready) tb = cyc;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 40 && rspq.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        nvec++; if (tb - ta !== 3 + L) begin nerr++; $display("[TB] FAIL b2b_accept_gap: got %0d expected %0d", tb - ta, 3 + L); end
        nvec++;
        if (rspq.size() !== 2) begin
            nerr++; $display("[TB] FAIL b2b_rsp_count: got %0d expected 2", rspq.size());
        end else begin
            nvec++; if (rspq[0].rdata !== 32'h44332211) begin nerr++; $display("[TB] FAIL b2b_rdata0: got %h expected 44332211", rspq[0].rdata); end
            nvec++; if (rspq[0].cyc - ta !== 2 + L) begin nerr++; $display("[TB] FAIL b2b_latency0: got %0d expected %0d", rspq[0].cyc - ta, 2 + L); end
            nvec++; if (rspq[1].rdata !== 32'h00000077) begin nerr++; $display("[TB] FAIL b2b_rdata1: got %h expected 00000077", rspq[1].rdata); end
            nvec++; if (rspq[1].cyc - tb !== 2 + L) begin nerr++; $display("[TB] FAIL b2b_latency1: got %0d expected %0d", rspq[1].cyc - tb, 2 + L); end
        end
    endtask

    task automatic test_random();
        int          ta, tr, elat, enops;
        logic [31:0] rd, erd, a, wd;
        logic        er, eer, we;
        logic [2:0]  t;
        memop_t      eops [2];
        for (int w = 0; w < 6; w++) preload(30'hC0 + 30'(w), $urandom);
        preload(30'h3FFFFFFE, $urandom);
        preload(30'h3FFFFFFF, $urandom);
        preload(30'h0, $urandom);
        preload(30'h1, $urandom);
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            t  = 3'($urandom_range(0, 7));
            a  = (($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : 32'h00000300) + 32'($urandom_range(0, 15));
            wd = $urandom;
            model_req(we, t, a, wd, erd, eer, elat, enops, eops);
            drive_req(we, t, a, wd, ta, tr, rd, er);
            nvec++; if (tr - ta !== elat) begin nerr++; $display("[TB] FAIL rnd%0d_latency: we=%b type=%b addr=%h got %0d expected %0d", n, we, t, a, tr - ta, elat); end
            nvec++; if (rd !== erd) begin nerr++; $display("[TB] FAIL rnd%0d_rdata: we=%b type=%b addr=%h got %h expected %h", n, we, t, a, rd, erd); end
            nvec++; if (er !== eer) begin nerr++; $display("[TB] FAIL rnd%0d_err: type=%b got %b expected %b", n, t, er, eer); end
            nvec++; if (memq.size() !== enops) begin nerr++; $display("[TB] FAIL rnd%0d_mem_count: got %0d expected %0d", n, memq.size(), enops); end
            for (int i = 0; i < enops && i < memq.size(); i++) begin
                nvec++; if (memq[i].addr !== eops[i].addr) begin nerr++; $display("[TB] FAIL rnd%0d_op%0d_addr: got %h expected %h", n, i, memq[i].addr, eops[i].addr); end
                nvec++; if (memq[i].we !== eops[i].we) begin nerr++; $display("[TB] FAIL rnd%0d_op%0d_we: got %b expected %b", n, i, memq[i].we, eops[i].we); end
                nvec++; if (memq[i].wdata !== eops[i].wdata) begin nerr++; $display("[TB] FAIL rnd%0d_op%0d_wdata: got %h expected %h", n, i, memq[i].wdata, eops[i].wdata); end
                nvec++; if (memq[i].cyc - ta !== eops[i].cyc) begin nerr++; $display("[TB] FAIL rnd%0d_op%0d_cycle: got %0d expected %0d", n, i, memq[i].cyc - ta, eops[i].cyc); end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_type  = 3'b010;
        req_addr  = 32'h100;
        req_wdata = $urandom;
        test_reset();
        test_load_byte();
        test_store_half();
        test_split_load();
        test_split_store_wrap();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
